mio_bus_arbiter: RTL
====================

Name: mio_bus_arbiter

Overview:
- Sequencer/arbiter that shares the CPU's single memory/IO port (CPU_MIO / MIO_ready handshake) between two requesters: instruction fetch and data load/store.
- Sits between the multi-cycle datapath/control FSM and the external memory/peripheral bus.
- Registers each access, waits for bus ready, returns read data with a one-cycle done pulse, and exports a busy/stall indication to the control FSM.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte enables DW/8).
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win.
- TIMEOUT_CYCLES, 255, BUSY-cycle limit before an access is aborted (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  AW  fetch address.
- if_done  out  1  one-cycle pulse: fetch complete, rdata valid.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DW/8  store byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- rdata  out  DW  read data for the requester being completed.
- bus_req  out  1  bus access active (CPU_MIO).
- bus_we  out  1  bus write strobe (mem_w).
- bus_addr  out  AW  registered address.
- bus_wdata  out  DW  registered write data.
- bus_be  out  DW/8  registered byte enables.
- bus_rdata  in  DW  bus read data.
- bus_ready  in  1  bus completion (MIO_ready).
- busy  out  1  state != IDLE; stall to the control FSM.
- err  out  1  completion was a timeout abort; valid with the done pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; starve counter 0; timeout counter 0. Reset mid-access drops bus_req immediately, with no done pulse.
- States: IDLE, BUSY, RESP.
- IDLE: arbitrate on registered-edge sampling.
  - d_req alone wins.
  - if_req alone wins.
  - If both are high, data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - The winner's addr/we/be/wdata are latched into the bus_* registers; fetch forces we=0 and be=all-ones. Then go to BUSY.
  - No request: stay in IDLE.
- Starve counter:
  - Increments when both requests are high and data wins.
  - Clears whenever fetch wins.
  - Saturates at STARVE_MAX.
- BUSY:
  - bus_req=1; bus_* are held stable.
  - On bus_ready=1 at a clock edge:
    - For a load or fetch, capture bus_rdata into rdata.
    - For a store, set rdata to 0.
    - Go to RESP.
  - Changes on the requester inputs during BUSY are ignored.
- RESP:
  - bus_req=0, bus_we=0.
  - Exactly one of if_done/d_done is 1; rdata is valid.
  - New requests are not sampled in this cycle, so a requester still holding req does not re-trigger.
  - Next state is always IDLE.
- Latency:
  - req sampled at edge N puts the FSM in BUSY during cycle N+1.
  - A zero-wait bus (ready high in the first BUSY cycle) gives done in cycle N+2.
  - Each wait state adds 1 cycle.
  - Minimum occupancy is 3 cycles per access, including the IDLE cycle.
- rdata holds its value outside RESP until the next capture.
- busy = (state != IDLE).
- bus_we = bus_req & latched we.

Optional Feature:
- Macro MIO_ARB_TIMEOUT_EN.
- Defined:
  - A counter counts BUSY cycles and clears on entry to BUSY.
  - If the count reaches TIMEOUT_CYCLES without bus_ready, the access is aborted: go to RESP with rdata=0 and err=1 during the done pulse.
  - bus_ready arriving in the same cycle as the limit counts as a normal completion (ready has priority).
- Undefined:
  - No counter; BUSY waits indefinitely.
  - err is tied to 0.

Decomposition:
- Shared package (the existing define header):
  - state encodings ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RESP=2'd2.
  - grant encodings GNT_IF=1'b0, GNT_D=1'b1.
- One natural sub-module: mio_arb_starve, the saturating starve counter plus priority decision; it outputs grant_d.
- The FSM and bus registers stay in the top module.

Test Plan:
- Fetch only, zero-wait:
  - Stimulus: if_req=1, if_addr=0x0000_0040, bus_ready=1 during BUSY, bus_rdata=0x2008_0005.
  - Response: bus_req high for 1 cycle with bus_addr=0x40 and bus_we=0; if_done pulses 1 cycle later with rdata=0x2008_0005.
- Store with 3 wait states:
  - Stimulus: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF; bus_ready asserted in the 4th BUSY cycle.
  - Response: bus_we=1 for 4 cycles with addr/data/be stable; d_done pulses with rdata=0; busy is high for 5 cycles.
- Simultaneous requests, both held continuously:
  - Stimulus: d_req and if_req high together for repeated rounds.
  - Response: grants are D,D,D,D,IF,D,...; fetch wins on the 5th arbitration when STARVE_MAX=4.
- Held request after done:
  - Stimulus: d_req kept high through RESP and dropped the cycle after d_done.
  - Response: exactly one bus access, with no second bus_req.
- Reset mid-access:
  - Stimulus: rst_n=0 during BUSY.
  - Response: bus_req=0 and busy=0 asynchronously, no done pulse; after release, a new if_req completes normally.
- MIO_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - Stimulus: bus_ready held at 0.
  - Response: after 8 BUSY cycles, d_done=1, err=1, rdata=0.
  - Additional check: bus_ready=1 on the 8th cycle gives normal completion with err=0.

Source files
------------

// File: rtl/mio_bus_arbiter_pkg.sv
// Shared encodings for the memory/IO port arbiter: FSM states and grant codes.
package mio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

endpackage

// File: rtl/mio_arb_starve.sv
// Fetch-vs-data priority decision with a saturating starvation counter.
module mio_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic grant_d_o
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          starved;

    assign starved   = (starve_q == STARVE_LIM);
    // Data wins by default; fetch only preempts once it has lost STARVE_MAX times in a row.
    assign grant_d_o = d_req_i & ~(if_req_i & starved);

    always_comb begin
        starve_d = starve_q;
        if (arb_en_i) begin
            if (if_req_i & ~grant_d_o) begin
                starve_d = '0;
            end else if (if_req_i & d_req_i & ~starved) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one memory/IO bus port between instruction fetch and data load/store.
// Optional access timeout is enabled with `define MIO_ARB_TIMEOUT_EN.
module mio_bus_arbiter
    import mio_bus_arbiter_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_done,
    output logic [DW-1:0]   rdata,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_be,
    input  logic [DW-1:0]   bus_rdata,
    input  logic            bus_ready,
    output logic            busy,
    output logic            err
);
    localparam int BW = DW / 8;

    arb_state_e       state_q;
    grant_e           gnt_q;
    logic             we_q;
    logic             bus_req_q;
    logic             bus_we_q;
    logic [AW-1:0]    bus_addr_q;
    logic [DW-1:0]    bus_wdata_q;
    logic [BW-1:0]    bus_be_q;
    logic [DW-1:0]    rdata_q;
    logic             if_done_q;
    logic             d_done_q;
    logic             grant_d;

    mio_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en_i  (state_q == ARB_IDLE),
        .if_req_i  (if_req),
        .d_req_i   (d_req),
        .grant_d_o (grant_d)
    );

`ifdef MIO_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_IF;
            we_q        <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rdata_q     <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
`ifdef MIO_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
`ifdef MIO_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state_q)
                ARB_IDLE: begin
                    if (if_req | d_req) begin
                        state_q   <= ARB_BUSY;
                        bus_req_q <= 1'b1;
`ifdef MIO_ARB_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                        if (grant_d) begin
                            gnt_q       <= GNT_D;
                            we_q        <= d_we;
                            bus_we_q    <= d_we;
                            bus_addr_q  <= d_addr;
                            bus_wdata_q <= d_wdata;
                            bus_be_q    <= d_be;
                        end else begin
                            gnt_q       <= GNT_IF;
                            we_q        <= 1'b0;
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= if_addr;
                            bus_wdata_q <= '0;
                            bus_be_q    <= '1;
                        end
                    end
                end
                ARB_BUSY: begin
                    // Ready is checked first so a completion on the limit cycle is never reported as a timeout.
                    if (bus_ready) begin
                        state_q   <= ARB_RESP;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        rdata_q   <= we_q ? '0 : bus_rdata;
                        if_done_q <= (gnt_q == GNT_IF);
                        d_done_q  <= (gnt_q == GNT_D);
                    end
`ifdef MIO_ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q   <= ARB_RESP;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        if_done_q <= (gnt_q == GNT_IF);
                        d_done_q  <= (gnt_q == GNT_D);
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                ARB_RESP: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != ARB_IDLE);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign rdata     = rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;

endmodule
